// File: rtl/pc_stage_if.sv
// pc_stage_if: fetch-PC stage bus between CPU control, CSR block and the PC stage.
interface pc_stage_if #(
  parameter int ADR_W = 32,
  parameter int N_IRQ = 4,
  parameter int ID_W  = 4
);
  logic               cpu_start;
  logic               cpu_stat_pc;
  logic               stall;
  logic [ADR_W-3:0]   cpu_start_adr;
  logic               jmp_condition_ex;
  logic [ADR_W-3:0]   jmp_adr_ex;
  logic               cmd_mret_ex;
  logic               cmd_sret_ex;
  logic               ecall_condition_ex;
  logic               g_exception;
  logic               csr_mie;
  logic [N_IRQ-1:0]   csr_irq_en;
  logic [ADR_W-3:0]   csr_tvec_ex;
  logic               csr_tvec_mode;
  logic [ADR_W-3:0]   csr_mepc_ex;
  logic [ADR_W-3:0]   csr_sepc_ex;
  logic [N_IRQ-1:0]   irq_in;
  logic [ADR_W-3:0]   pc;
  logic [ADR_W-3:0]   pc_excep;
  logic [N_IRQ-1:0]   irq_pending;
  logic               intr_taken;
  logic [ID_W-1:0]    intr_id;
  modport master (
    output cpu_start, cpu_stat_pc, stall, cpu_start_adr, jmp_condition_ex, jmp_adr_ex,
           cmd_mret_ex, cmd_sret_ex, ecall_condition_ex, g_exception, csr_mie, csr_irq_en,
           csr_tvec_ex, csr_tvec_mode, csr_mepc_ex, csr_sepc_ex, irq_in,
    input  pc, pc_excep, irq_pending, intr_taken, intr_id
  );
  modport slave (
    input  cpu_start, cpu_stat_pc, stall, cpu_start_adr, jmp_condition_ex, jmp_adr_ex,
           cmd_mret_ex, cmd_sret_ex, ecall_condition_ex, g_exception, csr_mie, csr_irq_en,
           csr_tvec_ex, csr_tvec_mode, csr_mepc_ex, csr_sepc_ex, irq_in,
    output pc, pc_excep, irq_pending, intr_taken, intr_id
  );
endinterface

// File: rtl/pc_stage_vec.sv
// pc_stage_vec: RV32I fetch-PC stage with edge-latched prioritised interrupts and vectored traps.
// Define PC_STAGE_IRQ_SYNC_EN to pass irq_in through a 2-flop synchroniser before edge detect.
module pc_stage_vec #(
  parameter int ADR_W = 32,
  parameter int N_IRQ = 4,
  parameter int ID_W  = 4
) (
  input logic          clk,
  input logic          rst,
  pc_stage_if.slave    bus
);
  localparam int PW = ADR_W - 2;
  logic             adv, start_f, exc, irq_take, take;
  logic [N_IRQ-1:0] irq_d, irq_prev, rise, irq_req, clr;
  logic [ID_W-1:0]  irq_sel;
  logic [PW-1:0]    pc_inc, pc_ecall, irq_vec, pc_nxt;
`ifdef PC_STAGE_IRQ_SYNC_EN
  logic [N_IRQ-1:0] sync_0, sync_1;
  always_ff @(posedge clk or posedge rst)
    if (rst) {sync_1, sync_0} <= '0;
    else     {sync_1, sync_0} <= {sync_0, bus.irq_in};
  assign irq_d = sync_1;
`else
  assign irq_d = bus.irq_in;
`endif
  assign adv      = bus.cpu_stat_pc & ~bus.stall;
  assign rise     = irq_d & ~irq_prev;
  assign irq_req  = bus.irq_pending & bus.csr_irq_en;
  assign irq_take = |irq_req & bus.csr_mie;
  assign exc      = bus.ecall_condition_ex | bus.g_exception;
  // start load and synchronous traps both outrank the interrupt, leaving it pending
  assign take     = adv & ~start_f & ~exc & irq_take;
  assign clr      = take ? N_IRQ'(1) << irq_sel : '0;
  assign pc_inc   = bus.pc + PW'(1);
  assign irq_vec  = bus.csr_tvec_mode ? bus.csr_tvec_ex + PW'(irq_sel) : bus.csr_tvec_ex;
  always_comb begin
    irq_sel = '0;
    for (int i = N_IRQ - 1; i >= 0; i--)
      if (irq_req[i]) irq_sel = ID_W'(i);
  end
  always_comb begin
    pc_nxt = start_f                ? bus.cpu_start_adr :
             exc                    ? bus.csr_tvec_ex   :
             irq_take               ? irq_vec           :
             bus.cmd_mret_ex        ? bus.csr_mepc_ex   :
             bus.cmd_sret_ex        ? bus.csr_sepc_ex   :
             bus.jmp_condition_ex   ? bus.jmp_adr_ex    : pc_inc;
    bus.pc_excep = (bus.ecall_condition_ex & ~irq_take) ? pc_ecall :
                   bus.g_exception                      ? bus.pc   :
                   bus.jmp_condition_ex                 ? bus.jmp_adr_ex : pc_inc;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.pc          <= '0;
      bus.irq_pending <= '0;
      bus.intr_taken  <= 1'b0;
      bus.intr_id     <= '0;
      start_f         <= 1'b0;
      irq_prev        <= '0;
      pc_ecall        <= '0;
    end else begin
      irq_prev        <= irq_d;
      start_f         <= adv ? 1'b0 : (start_f | bus.cpu_start);
      bus.irq_pending <= (bus.irq_pending & ~clr) | (rise & bus.csr_irq_en);
      bus.intr_taken  <= take;
      if (take) bus.intr_id <= irq_sel;
      if (adv) bus.pc <= pc_nxt;
      if (adv & bus.ecall_condition_ex) pc_ecall <= pc_inc;
    end
  end
endmodule

// File: tb/tb_pc_stage_vec.sv
// tb_pc_stage_vec: table-driven directed vectors for pc_stage_vec, one clock per row.
module tb_pc_stage_vec;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  pc_stage_if #(.ADR_W(32), .N_IRQ(4), .ID_W(4)) bus ();
  pc_stage_vec #(.ADR_W(32), .N_IRQ(4), .ID_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic [31:0] st, sp, stl, jmp, jadr, mret, sret, ec, gx, mie, en, mode, irq, sadr;
    logic [31:0] e_pc, e_pend, e_it, e_id, e_x;
  } vec_t;
  vec_t tbl [40];
  int n_vec = 0;
  int n_err = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic drive(input vec_t v);
    bus.cpu_start          = v.st[0];
    bus.cpu_stat_pc        = v.sp[0];
    bus.stall              = v.stl[0];
    bus.jmp_condition_ex   = v.jmp[0];
    bus.jmp_adr_ex         = v.jadr[29:0];
    bus.cmd_mret_ex        = v.mret[0];
    bus.cmd_sret_ex        = v.sret[0];
    bus.ecall_condition_ex = v.ec[0];
    bus.g_exception        = v.gx[0];
    bus.csr_mie            = v.mie[0];
    bus.csr_irq_en         = v.en[3:0];
    bus.csr_tvec_mode      = v.mode[0];
    bus.irq_in             = v.irq[3:0];
    bus.cpu_start_adr      = v.sadr[29:0];
    bus.csr_tvec_ex        = 30'h40;
    bus.csr_mepc_ex        = 30'h21;
    bus.csr_sepc_ex        = 30'h300;
  endtask
  initial begin
    //          st sp stl jmp jadr  mret sret ec gx mie en     mode irq     sadr           pc            pend    it id x
    tbl[0]  = '{1, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0,      0, 0,      'h100,        0,            0,      0, 0, 1};
    tbl[1]  = '{0, 1, 0, 0, 0,     0, 0, 0, 0, 0, 0,      0, 0,      'h100,        'h100,        0,      0, 0, 'h101};
    tbl[2]  = '{0, 1, 0, 0, 0,     0, 0, 0, 0, 0, 0,      0, 0,      'h100,        'h101,        0,      0, 0, 'h102};
    tbl[3]  = '{0, 1, 0, 0, 0,     0, 0, 0, 0, 0, 0,      0, 0,      'h100,        'h102,        0,      0, 0, 'h103};
    tbl[4]  = '{0, 0, 0, 0, 0,     0, 0, 0, 0, 1, 'b1010, 1, 'b1010, 'h100,        'h102,        'b1010, 0, 0, 'h103};
    tbl[5]  = '{0, 1, 0, 0, 0,     0, 0, 0, 0, 1, 'b1010, 1, 'b1010, 'h100,        'h41,         'b1000, 1, 1, 'h42};
    tbl[6]  = '{0, 1, 0, 0, 0,     0, 0, 0, 0, 1, 'b1010, 1, 'b1010, 'h100,        'h43,         0,      1, 3, 'h44};
    tbl[7]  = '{0, 1, 0, 0, 0,     0, 0, 0, 0, 1, 'b1010, 1, 'b1010, 'h100,        'h44,         0,      0, 3, 'h45};
    tbl[8]  = '{0, 0, 0, 0, 0,     0, 0, 0, 0, 1, 'b1010, 1, 0,      'h100,        'h44,         0,      0, 3, 'h45};
    tbl[9]  = '{0, 0, 0, 0, 0,     0, 0, 0, 0, 1, 'b1010, 1, 'b0010, 'h100,        'h44,         'b0010, 0, 3, 'h45};
    tbl[10] = '{0, 1, 0, 0, 0,     0, 0, 0, 1, 1, 'b1010, 1, 'b0010, 'h100,        'h40,         'b0010, 0, 3, 'h40};
    tbl[11] = '{0, 1, 0, 0, 0,     0, 0, 0, 0, 1, 'b1010, 1, 'b0010, 'h100,        'h41,         0,      1, 1, 'h42};
    tbl[12] = '{0, 1, 0, 1, 'h20,  0, 0, 0, 0, 1, 'b1010, 1, 'b0010, 'h100,        'h20,         0,      0, 1, 'h20};
    tbl[13] = '{0, 1, 0, 0, 0,     0, 0, 1, 0, 1, 'b1010, 1, 'b0010, 'h100,        'h40,         0,      0, 1, 'h21};
    tbl[14] = '{0, 1, 0, 0, 0,     1, 0, 0, 0, 1, 'b1010, 1, 'b0010, 'h100,        'h21,         0,      0, 1, 'h22};
    tbl[15] = '{0, 1, 0, 0, 0,     0, 1, 0, 0, 1, 'b1010, 1, 'b0010, 'h100,        'h300,        0,      0, 1, 'h301};
    tbl[16] = '{0, 0, 0, 0, 0,     0, 0, 0, 0, 1, 'b1010, 1, 'b1000, 'h100,        'h300,        'b1000, 0, 1, 'h301};
    tbl[17] = '{0, 1, 1, 1, 'h55,  0, 0, 0, 0, 1, 'b1010, 1, 'b1000, 'h100,        'h300,        'b1000, 0, 1, 'h55};
    tbl[18] = '{0, 1, 0, 1, 'h55,  0, 0, 0, 0, 1, 'b1010, 1, 'b1000, 'h100,        'h43,         0,      1, 3, 'h55};
    tbl[19] = '{0, 1, 0, 1, 'h55,  0, 0, 0, 0, 1, 'b1010, 1, 'b1000, 'h100,        'h55,         0,      0, 3, 'h55};
    tbl[20] = '{0, 0, 0, 0, 0,     0, 0, 0, 0, 1, 'b1010, 0, 'b0010, 'h100,        'h55,         'b0010, 0, 3, 'h56};
    tbl[21] = '{0, 1, 0, 0, 0,     0, 0, 0, 0, 1, 'b1010, 0, 'b0010, 'h100,        'h40,         0,      1, 1, 'h41};
    tbl[22] = '{0, 0, 0, 0, 0,     0, 0, 0, 0, 1, 'b1010, 1, 0,      'h100,        'h40,         0,      0, 1, 'h41};
    tbl[23] = '{0, 0, 0, 0, 0,     0, 0, 0, 0, 1, 'b1010, 1, 'b1000, 'h100,        'h40,         'b1000, 0, 1, 'h41};
    tbl[24] = '{0, 0, 0, 0, 0,     0, 0, 0, 0, 1, 'b1010, 1, 0,      'h100,        'h40,         'b1000, 0, 1, 'h41};
    tbl[25] = '{0, 1, 0, 0, 0,     0, 0, 0, 0, 1, 'b1010, 1, 'b1000, 'h100,        'h43,         'b1000, 1, 3, 'h44};
    tbl[26] = '{0, 1, 0, 0, 0,     0, 0, 0, 0, 1, 'b1010, 1, 'b1000, 'h100,        'h43,         0,      1, 3, 'h44};
    tbl[27] = '{0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 'b1010, 1, 0,      'h100,        'h43,         0,      0, 3, 'h44};
    tbl[28] = '{0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 'b1010, 1, 'b0010, 'h100,        'h43,         'b0010, 0, 3, 'h44};
    tbl[29] = '{0, 1, 0, 0, 0,     0, 0, 0, 0, 0, 'b1010, 1, 'b0010, 'h100,        'h44,         'b0010, 0, 3, 'h45};
    tbl[30] = '{0, 1, 0, 0, 0,     0, 0, 0, 0, 1, 'b1010, 1, 'b0010, 'h100,        'h41,         0,      1, 1, 'h42};
    tbl[31] = '{1, 0, 0, 0, 0,     0, 0, 0, 0, 1, 'b1010, 1, 'b0010, 'h3FFFFFFF,   'h41,         0,      0, 1, 'h42};
    tbl[32] = '{0, 1, 0, 0, 0,     0, 0, 0, 0, 1, 'b1010, 1, 'b0010, 'h3FFFFFFF,   'h3FFFFFFF,   0,      0, 1, 0};
    tbl[33] = '{0, 1, 0, 0, 0,     0, 0, 0, 0, 1, 'b1010, 1, 'b0010, 'h3FFFFFFF,   0,            0,      0, 1, 1};
    tbl[34] = '{1, 1, 0, 0, 0,     0, 0, 0, 0, 1, 'b1010, 1, 'b0010, 'h3FFFFFFF,   1,            0,      0, 1, 2};
    tbl[35] = '{0, 1, 0, 0, 0,     0, 0, 0, 0, 1, 'b1010, 1, 'b0010, 'h3FFFFFFF,   2,            0,      0, 1, 3};
    tbl[36] = '{0, 0, 0, 0, 0,     0, 0, 0, 0, 1, 'b1010, 1, 'b0100, 'h3FFFFFFF,   2,            0,      0, 1, 3};
    tbl[37] = '{0, 0, 0, 0, 0,     0, 0, 0, 0, 1, 'b1010, 1, 'b1000, 'h3FFFFFFF,   2,            'b1000, 0, 1, 3};
    tbl[38] = '{0, 1, 0, 0, 0,     0, 0, 1, 0, 1, 'b1010, 1, 'b1000, 'h3FFFFFFF,   'h40,         'b1000, 0, 1, 'h41};
    tbl[39] = '{0, 1, 0, 0, 0,     0, 0, 0, 0, 1, 'b1010, 1, 'b1000, 'h3FFFFFFF,   'h43,         0,      1, 3, 'h44};
    drive(tbl[0]);
    bus.cpu_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset pc", {2'b0, bus.pc}, 0);
    chk("reset pending", {28'b0, bus.irq_pending}, 0);
    chk("reset intr_taken", {31'b0, bus.intr_taken}, 0);
    chk("reset intr_id", {28'b0, bus.intr_id}, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      @(posedge clk);
      #1;
      chk($sformatf("row%0d pc", i), {2'b0, bus.pc}, tbl[i].e_pc);
      chk($sformatf("row%0d pending", i), {28'b0, bus.irq_pending}, tbl[i].e_pend);
      chk($sformatf("row%0d intr_taken", i), {31'b0, bus.intr_taken}, tbl[i].e_it);
      chk($sformatf("row%0d intr_id", i), {28'b0, bus.intr_id}, tbl[i].e_id);
      chk($sformatf("row%0d pc_excep", i), {2'b0, bus.pc_excep}, tbl[i].e_x);
    end
    // latch a fresh pending bit, then hit reset between clock edges
    @(negedge clk);
    bus.cpu_stat_pc = 1'b0;
    bus.irq_in = 4'b0000;
    @(negedge clk);
    bus.irq_in = 4'b0010;
    @(posedge clk);
    #1;
    chk("pre-reset pending", {28'b0, bus.irq_pending}, 'b0010);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async reset pc", {2'b0, bus.pc}, 0);
    chk("async reset pending", {28'b0, bus.irq_pending}, 0);
    chk("async reset intr_id", {28'b0, bus.intr_id}, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.cpu_start = 1'b1;
    bus.cpu_start_adr = 30'h100;
    @(negedge clk);
    bus.cpu_start = 1'b0;
    bus.cpu_stat_pc = 1'b1;
    @(posedge clk);
    #1;
    chk("restart pc", {2'b0, bus.pc}, 'h100);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
